// File: rtl/prog_mem_pkg.sv
// Shared types and constants for the fetch-stage instruction memory.
package prog_mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  // Value written to every word by the post-reset clear sequence.
  localparam logic [31:0] FILL_WORD_DEFAULT = 32'h0000_0000;

  // ARM encodings benches commonly fill or terminate programs with.
  localparam logic [31:0] ARM_NOP  = 32'hE1A0_0000;  // mov r0, r0
  localparam logic [31:0] ARM_HALT = 32'hEAFF_FFFE;  // b .

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/prog_mem_array.sv
// Synchronous 1R1W word array with a registered read port, no reset,
// read-before-write on an index collision. Maps onto block RAM.
module prog_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write and registered read on the same edge; the read sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/prog_mem.sv
// Instruction memory for the fetch stage: valid/ready fetch port with a
// one-cycle registered response, host loader port, and a hardware clear of
// the whole array after reset. Bad fetch addresses are flagged, not aliased.
module prog_mem
  import prog_mem_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 256,
  parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(FILL_WORD_DEFAULT),
  localparam int               IDX_W     = idx_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  output logic              fetch_ready,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [IDX_W-1:0]  ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              busy
);

  state_t            state;
  logic [IDX_W-1:0]  clr_ptr;

  logic              fetch_fire_p0;
  logic              fetch_err_p0;
  logic [IDX_W-1:0]  fetch_idx_p0;

  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;

  logic              rsp_rd_p1;
  logic [DATA_W-1:0] ram_q_p1;

  assign busy        = (state == CLEAR);
  assign ld_ready    = (state == IDLE);
  assign fetch_ready = (state == IDLE) && (!rsp_valid || rsp_ready);

  // A fetch is in error when misaligned or when any bit above the word index
  // is set, so out-of-range addresses never wrap onto a real word.
  assign fetch_idx_p0  = fetch_addr[IDX_W+1:2];
  assign fetch_err_p0  = (fetch_addr[1:0] != 2'b00) ||
                         ((fetch_addr >> (IDX_W + 2)) != '0);
  assign fetch_fire_p0 = fetch_valid && fetch_ready && !rst;

  // Single write port shared by the clear sequence and the loader.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = clr_ptr;
    wr_data = FILL_WORD;
    if (!rst) begin
      if (state == CLEAR) begin
        wr_en = 1'b1;
      end else if (ld_valid) begin
        wr_en   = 1'b1;
        wr_idx  = ld_addr;
        wr_data = ld_data;
      end
    end
  end

  prog_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .rd_en   (fetch_fire_p0 && !fetch_err_p0),
    .rd_idx  (fetch_idx_p0),
    .rd_data (ram_q_p1),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data)
  );

  // ---- p0 -> p1: accepted fetch becomes the registered response ----
  // The RAM output register holds while no read is issued, so a stalled
  // response stays stable; rsp_rd_p1 masks it to zero on errors and reset.
  assign rsp_data = rsp_rd_p1 ? ram_q_p1 : '0;

  // Clear/serve FSM plus the response valid/error/select flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      clr_ptr   <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rd_p1 <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + IDX_W'(1);
          if (clr_ptr == IDX_W'(DEPTH - 1)) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (fetch_fire_p0) begin
            rsp_valid <= 1'b1;
            rsp_err   <= fetch_err_p0;
            rsp_rd_p1 <= !fetch_err_p0;
          end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_mem.sv
// Bench for prog_mem: behavioural model plus per-cycle compare, and directed
// sequences with hand-computed expected words.
module tb_prog_mem;

  localparam int          DEPTH = 16;
  localparam logic [31:0] FILL  = 32'hE1A00000;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        ld_valid;
  logic        ld_ready;
  logic [3:0]  ld_addr;
  logic [31:0] ld_data;
  logic        busy;

  int tests = 0;
  int fails = 0;

  prog_mem #(
    .DATA_W    (32),
    .ADDR_W    (32),
    .DEPTH     (DEPTH),
    .FILL_WORD (FILL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .fetch_addr  (fetch_addr),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [DEPTH];
  int          m_clear_left = 0;
  bit          m_known = 1'b0;
  bit          m_rsp_valid = 1'b0;
  logic [31:0] m_rsp_data = 32'h0;
  bit          m_rsp_err = 1'b0;
  bit          m_fresh = 1'b0;

  always @(posedge clk) begin
    int unsigned a;
    bit          err;
    if (rst) begin
      m_known      = 1'b1;
      m_clear_left = DEPTH;
      m_rsp_valid  = 1'b0;
      m_rsp_data   = 32'h0;
      m_rsp_err    = 1'b0;
      m_fresh      = 1'b1;
    end else if (m_known) begin
      if (m_clear_left > 0) begin
        m_clear_left--;
        if (m_clear_left == 0) begin
          for (int k = 0; k < DEPTH; k++) m_mem[k] = FILL;
        end
      end else begin
        if (fetch_valid && (!m_rsp_valid || rsp_ready)) begin
          a           = fetch_addr;
          err         = (a % 4 != 0) || (a >= 4 * DEPTH);
          m_rsp_valid = 1'b1;
          m_rsp_err   = err;
          m_rsp_data  = err ? 32'h0 : m_mem[a / 4];
          m_fresh     = 1'b0;
        end else if (m_rsp_valid && rsp_ready) begin
          m_rsp_valid = 1'b0;
        end
        if (ld_valid) m_mem[ld_addr] = ld_data;
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (m_known) begin
      chk("busy", busy, m_clear_left > 0);
      chk("ld_ready", ld_ready, m_clear_left == 0);
      chk("fetch_ready", fetch_ready, (m_clear_left == 0) && (!m_rsp_valid || rsp_ready));
      chk("rsp_valid", rsp_valid, m_rsp_valid);
      if (m_rsp_valid || m_fresh) begin
        chk("rsp_data", rsp_data, m_rsp_data);
        chk("rsp_err", rsp_err, m_rsp_err);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic count_clear(input string nm);
    int cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      cnt++;
      tick();
    end
    chk(nm, cnt, DEPTH);
  endtask

  task automatic load1(input logic [3:0] idx, input logic [31:0] d);
    ld_valid = 1'b1;
    ld_addr  = idx;
    ld_data  = d;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic fetch1(input string nm, input logic [31:0] a,
                        input logic [31:0] ed, input logic ee);
    int n = 0;
    fetch_valid = 1'b1;
    fetch_addr  = a;
    rsp_ready   = 1'b1;
    #1;
    while (!fetch_ready && n < 50) begin
      tick();
      n++;
    end
    if (!fetch_ready) begin
      chk({nm, "_accept"}, fetch_ready, 1);
      fetch_valid = 1'b0;
      return;
    end
    tick();
    fetch_valid = 1'b0;
    chk({nm, "_vld"}, rsp_valid, 1);
    chk({nm, "_data"}, rsp_data, ed);
    chk({nm, "_err"}, rsp_err, ee);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; fetch_valid = 1'b0; fetch_addr = 32'h0; rsp_ready = 1'b1;
    ld_valid = 1'b0; ld_addr = 4'h0; ld_data = 32'h0;

    // Reset held for three cycles.
    tick(); tick(); tick();
    chk("rst_busy", busy, 1);
    chk("rst_fetch_ready", fetch_ready, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_err", rsp_err, 0);
    rst = 1'b0;
    count_clear("clear_len");

    // Every word reads back the fill value, streamed one per cycle.
    for (int i = 0; i < DEPTH; i++) begin
      fetch_valid = 1'b1;
      fetch_addr  = 32'(4 * i);
      tick();
      chk("fill_vld", rsp_valid, 1);
      chk("fill_data", rsp_data, FILL);
      chk("fill_err", rsp_err, 0);
    end
    fetch_valid = 1'b0;
    tick();

    // Load then fetch the next cycle.
    load1(4'd5, 32'hE3A00014);
    fetch1("ld_fetch", 32'h14, 32'hE3A00014, 1'b0);

    // Distinct words for streaming and collision.
    load1(4'd0, 32'hA0A0A0A0);
    load1(4'd1, 32'hB1B1B1B1);
    load1(4'd2, 32'h11111111);
    load1(4'd3, 32'hC3C3C3C3);

    // Streaming with one stall cycle.
    rsp_ready = 1'b1; fetch_valid = 1'b1; fetch_addr = 32'h0;
    tick();
    chk("str0", rsp_data, 32'hA0A0A0A0);
    fetch_addr = 32'h4;
    tick();
    chk("str1", rsp_data, 32'hB1B1B1B1);
    fetch_addr = 32'h8; rsp_ready = 1'b0;
    #1;
    chk("stall_fetch_ready", fetch_ready, 0);
    tick();
    chk("stall_vld", rsp_valid, 1);
    chk("stall_hold", rsp_data, 32'hB1B1B1B1);
    rsp_ready = 1'b1;
    tick();
    chk("str2", rsp_data, 32'h11111111);
    fetch_addr = 32'hC;
    tick();
    chk("str3", rsp_data, 32'hC3C3C3C3);
    fetch_valid = 1'b0;
    tick();
    chk("str_drain", rsp_valid, 0);

    // Error addresses.
    fetch1("err_misalign", 32'h6, 32'h0, 1'b1);
    fetch1("err_range", 32'(4 * DEPTH), 32'h0, 1'b1);
    fetch1("err_high", 32'h0001_0000, 32'h0, 1'b1);
    fetch1("last_word", 32'h3C, FILL, 1'b0);

    // Same-index load and fetch: old word first, new word next.
    ld_valid = 1'b1; ld_addr = 4'd2; ld_data = 32'hAAAA0000;
    fetch_valid = 1'b1; fetch_addr = 32'h8; rsp_ready = 1'b1;
    tick();
    ld_valid = 1'b0; fetch_valid = 1'b0;
    chk("coll_old", rsp_data, 32'h11111111);
    fetch1("coll_new", 32'h8, 32'hAAAA0000, 1'b0);
    tick();

    // Reset with a stalled response in flight.
    rsp_ready = 1'b0; fetch_valid = 1'b1; fetch_addr = 32'h4;
    tick();
    fetch_valid = 1'b0;
    chk("mid_vld_before", rsp_valid, 1);
    rst = 1'b1;
    tick();
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_busy", busy, 1);
    chk("mid_rsp_data", rsp_data, 32'h0);
    rst = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    count_clear("reclear_len");

    // Clear overwrote earlier loads.
    fetch1("post_clr5", 32'h14, FILL, 1'b0);
    fetch1("post_clr2", 32'h8, FILL, 1'b0);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
